debug_readout_sequencer: RTL

Sequences debug readout from the MIPS datapath to the MicroBlaze. On a read request it latches the requested group and steps a word index through that group's fixed-length strip. Each word is sent as a 32-bit frame under a valid/ack handshake, and the strip is closed with an end-of-data (EoD) frame. It sits between the MicroBlaze command decoder (request pulse and 6-bit select) and the datapath debug read muxes (word select/index in, word data out).

---
 rtl/debug_seq_pkg.sv | 10 +
 rtl/debug_select_decoder.sv | 16 +
 rtl/debug_readout_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/debug_seq_pkg.sv
// debug_seq_pkg: shared state encoding, select codes and EoD default for the debug readout path
package debug_seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, EOD} state_t;
  localparam logic [5:0] SEL_MEM_DATA = 6'b100000;
  localparam logic [5:0] SEL_MEM_INSTR = 6'b100001;
  localparam logic [5:0] SEL_PC = 6'b100010;
  localparam logic [3:0] SEL_LATCH_A = 4'b1001;
  localparam logic [3:0] SEL_LATCH_B = 4'b1010;
  localparam logic [31:0] EOD_PATTERN_DEFAULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/debug_select_decoder.sv
// debug_select_decoder: maps a 6-bit readout select to its strip length (0 means EoD only)
module debug_select_decoder
  import debug_seq_pkg::*;
#(
  parameter int NB_WORD_IDX = 4,
  parameter int N_LATCH_WORDS = 8
) (
  input  logic [5:0]           select,
  output logic [NB_WORD_IDX:0] n
);
  localparam logic [NB_WORD_IDX:0] ONE = 1;
  localparam logic [NB_WORD_IDX:0] LATCH = (NB_WORD_IDX + 1)'(N_LATCH_WORDS);
  assign n = !select[5] ? ONE :
             (select == SEL_MEM_DATA || select == SEL_MEM_INSTR || select == SEL_PC) ? ONE :
             (select[5:2] == SEL_LATCH_A || select[5:2] == SEL_LATCH_B) ? LATCH : '0;
endmodule

// File: rtl/debug_readout_sequencer.sv
// debug_readout_sequencer: walks a datapath debug strip out as acked frames closed by an EoD frame.
// Define DEBUG_SEQ_TIMEOUT_EN to add an ack watchdog that aborts a stalled strip.
module debug_readout_sequencer
  import debug_seq_pkg::*;
#(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_REQ_SELECT = 6,
  parameter int NB_WORD_IDX = 4,
  parameter int N_LATCH_WORDS = 8,
  parameter logic [NB_CONTROL_FRAME-1:0] EOD_PATTERN = EOD_PATTERN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_read_request,
  input  logic [NB_REQ_SELECT-1:0]    i_request_select,
  output logic [NB_REQ_SELECT-1:0]    o_word_select,
  output logic [NB_WORD_IDX-1:0]      o_word_index,
  input  logic [NB_CONTROL_FRAME-1:0] i_word_data,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  output logic                        o_frame_valid,
  output logic                        o_frame_last,
  input  logic                        i_frame_ack,
  output logic                        o_busy,
  output logic                        o_req_dropped,
  output logic                        o_timeout
);
  state_t state;
  logic [NB_WORD_IDX:0] n;
  logic [NB_WORD_IDX:0] strip_len;
  logic last_word;
  logic expired;
  debug_select_decoder #(.NB_WORD_IDX(NB_WORD_IDX), .N_LATCH_WORDS(N_LATCH_WORDS)) u_dec (
    .select(i_request_select),
    .n     (n)
  );
  assign o_busy = state != IDLE;
  assign o_req_dropped = i_read_request && o_busy;
  assign last_word = ({1'b0, o_word_index} + 1'b1) == strip_len;
`ifdef DEBUG_SEQ_TIMEOUT_EN
  localparam int NB_TO = $clog2(TIMEOUT_CYCLES + 1);
  logic [NB_TO-1:0] wait_cnt;
  assign expired = o_frame_valid && !i_frame_ack && wait_cnt == NB_TO'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clock) begin
    wait_cnt <= (i_reset || !o_frame_valid || i_frame_ack || expired) ? '0 : wait_cnt + 1'b1;
    o_timeout <= !i_reset && expired;
  end
`else
  assign expired = 1'b0;
  assign o_timeout = 1'b0;
`endif
  // Select and index stay latched after the strip so the datapath mux does not move until the next request
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state <= IDLE;
      o_word_select <= '0;
      o_word_index <= '0;
      strip_len <= '0;
      o_frame_to_blaze <= '0;
      o_frame_valid <= 1'b0;
      o_frame_last <= 1'b0;
    end else if (expired) begin
      state <= IDLE;
      o_frame_valid <= 1'b0;
      o_frame_last <= 1'b0;
    end else
      case (state)
        IDLE: if (i_read_request) begin
          o_word_select <= i_request_select;
          strip_len <= n;
          o_word_index <= '0;
          if (n == '0) begin
            state <= EOD;
            o_frame_to_blaze <= EOD_PATTERN;
            o_frame_valid <= 1'b1;
            o_frame_last <= 1'b1;
          end else state <= FETCH;
        end
        FETCH: begin
          o_frame_to_blaze <= i_word_data;
          o_frame_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (i_frame_ack) begin
          if (last_word) begin
            state <= EOD;
            o_frame_to_blaze <= EOD_PATTERN;
            o_frame_last <= 1'b1;
          end else begin
            state <= FETCH;
            o_frame_valid <= 1'b0;
            o_word_index <= o_word_index + 1'b1;
          end
        end
        EOD: if (i_frame_ack) begin
          state <= IDLE;
          o_frame_valid <= 1'b0;
          o_frame_last <= 1'b0;
        end
      endcase
endmodule
